// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle LEGv8 ALU: op codes, FSM states
// and status-flag bit positions.
package alu_mc_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_LSL  = 3'b100;
    localparam logic [2:0] OP_LSR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_UDIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    function automatic logic is_multi_cycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_UDIV);
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle for WIDTH cycles. result_o is the value the accumulator takes at the edge done_o is high.
module alu_mc_muldiv #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // For DIV, acc holds the dividend shifting out at the top while quotient
    // bits shift in at the bottom.
    assign rem_sh = {rem_q, acc_q[WIDTH-1]};
    assign fits   = rem_sh >= {1'b0, y_q};
    assign diff   = rem_sh[WIDTH-1:0] - y_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(WIDTH - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        div_d = div_q;
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        rem_d = rem_q;
        if (start_i) begin
            div_d = div_i;
            acc_d = div_i ? a_i : '0;
            x_d   = a_i;
            y_d   = b_i;
            rem_d = '0;
        end else if (busy_q) begin
            if (div_q) begin
                acc_d = {acc_q[WIDTH-2:0], fits};
                rem_d = fits ? diff : rem_sh[WIDTH-1:0];
            end else begin
                acc_d = y_q[0] ? acc_q + x_q : acc_q;
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        div_q <= div_d;
        acc_q <= acc_d;
        x_q   <= x_d;
        y_q   <= y_d;
        rem_q <= rem_d;
    end

    assign done_o   = busy_q && (cnt_q == '0);
    assign result_o = acc_d;

endmodule

// File: rtl/alu_mc_legv8.sv
// Registered LEGv8 ALU with valid/ready handshakes: single-cycle logic/add/
// shift ops plus iterative MUL and UDIV delegated to alu_mc_muldiv.
module alu_mc_legv8
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    input  logic [4:0]       fs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [3:0]       status
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [3:0]       status_q, status_d;

    logic [2:0]       op;
    logic             accept;
    logic             multi;
    logic [WIDTH-1:0] as, bs;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic [3:0]       sc_status;
    logic             md_start, md_done;
    logic [WIDTH-1:0] md_res;

    assign op     = fs[4:2];
    assign multi  = is_multi_cycle(op);
    assign as     = fs[0] ? ~a : a;
    assign bs     = fs[1] ? ~b : b;
    assign sum_ext = {1'b0, as} + {1'b0, bs} + {{WIDTH{1'b0}}, c0};

    // Held low during reset so nothing is accepted before the FSM is live.
    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign md_start = accept && multi;

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            OP_AND: sc_res = as & bs;
            OP_OR:  sc_res = as | bs;
            OP_ADD: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = ~(as[WIDTH-1] ^ bs[WIDTH-1]) & (sum_ext[WIDTH-1] ^ as[WIDTH-1]);
            end
            OP_XOR: sc_res = as ^ bs;
            OP_LSL: sc_res = a << b[SHAMT_W-1:0];
            OP_LSR: sc_res = a >> b[SHAMT_W-1:0];
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        sc_status       = '0;
        sc_status[ST_V] = sc_v;
        sc_status[ST_C] = sc_c;
        sc_status[ST_N] = sc_res[WIDTH-1];
        sc_status[ST_Z] = (sc_res == '0);
    end

    alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (md_start),
        .div_i    (op[0]),
        .a_i      (a),
        .b_i      (b),
        .done_o   (md_done),
        .result_o (md_res)
    );

    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        status_d = status_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (multi) begin
                        state_d = EXEC;
                    end else begin
                        state_d  = DONE;
                        f_d      = sc_res;
                        status_d = sc_status;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (md_done) begin
                    state_d        = DONE;
                    f_d            = md_res;
                    status_d       = '0;
                    status_d[ST_N] = md_res[WIDTH-1];
                    status_d[ST_Z] = (md_res == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            f_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            status_q <= status_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign f         = f_q;
    assign status    = status_q;

endmodule
